mem_access_ctrl: RTL and testbench

- Memory-stage controller on the consumer side of the EX/MEM pipeline latch.
- Takes the latched memory controls, address and store data, and issues one data-cache request per load or store.
- Holds the pipeline via mem_stall until the cache returns dhit, then presents registered write-back fields to the MEM/WB latch.
- Owns the sticky halt indication and a stall-cycle performance counter.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/mem_link_reg.sv | 49 ++++
 rtl/mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Types shared by the memory-stage controller and its link register.
// Holds the controller state encoding and the machine word type.
package cpu_types_pkg;

    localparam int WORD_W_DEF = 32;

    typedef logic [WORD_W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } memctl_state_t;

endpackage

// File: rtl/mem_link_reg.sv
// LL/SC reservation: one valid bit plus the reserved address, cleared by
// a matching snoop invalidate or a successful SC. A same-cycle LL set wins.
module mem_link_reg
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set_i,
    input  logic [WORD_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    input  logic [WORD_W-1:0] chk_addr_i,
    output logic              link_hit_o
);

    logic              link_valid_q, link_valid_d;
    logic [WORD_W-1:0] link_addr_q, link_addr_d;

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (snoop_inv && (snoop_addr == link_addr_q)) begin
            link_valid_d = 1'b0;
        end
        if (clr_i) begin
            link_valid_d = 1'b0;
        end
        if (set_i) begin
            link_valid_d = 1'b1;
            link_addr_d  = set_addr_i;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign link_hit_o = link_valid_q && (link_addr_q == chk_addr_i);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: one dcache request per load/store, stalls until dhit,
// registers write-back fields, sticky halt, saturating stall counter.
// Optional LL/SC support is compiled in with MEM_ACCESS_LLSC_EN.
//
// state  | meaning
// IDLE   | evaluate EX/MEM latch: pass-through, start an access, or halt
// ACCESS | request held on the cache until dhit
// DONE   | result presented, stall released for one cycle
module mem_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
`ifdef MEM_ACCESS_LLSC_EN
    input  logic              ll_i,
    input  logic              sc_i,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
`endif
    input  logic              DRen_i,
    input  logic              DWen_i,
    input  logic              RegW_i,
    input  logic [REG_W-1:0]  RegDest_i,
    input  logic [WORD_W-1:0] alu_out_i,
    input  logic [WORD_W-1:0] rdat2_i,
    input  logic              halt_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic              wb_regw,
    output logic [REG_W-1:0]  wb_rd,
    output logic [WORD_W-1:0] wb_data,
    output logic              halt_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [WORD_W-1:0] SC_OK_WORD = WORD_W'(1);

    memctl_state_t     state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d, store_q, store_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic              regw_q, regw_d, rd_kind_q, rd_kind_d;
    logic              wb_valid_q, wb_valid_d, wb_regw_q, wb_regw_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic              halt_q, halt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              ll_req, sc_req, sc_lat, link_hit;
    logic              mem_op, sc_fail;

    assign mem_op  = (DRen_i | DWen_i | ll_req | sc_req) & ~halt_q;
    assign sc_fail = sc_req & ~link_hit;

`ifdef MEM_ACCESS_LLSC_EN
    logic ll_q, ll_d, sc_q, sc_d;

    always_comb begin
        ll_d = ll_q;
        sc_d = sc_q;
        if (state_q == IDLE && mem_op) begin
            ll_d = ll_i;
            sc_d = sc_i;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ll_q <= 1'b0;
            sc_q <= 1'b0;
        end else begin
            ll_q <= ll_d;
            sc_q <= sc_d;
        end
    end

    assign ll_req = ll_i;
    assign sc_req = sc_i;
    assign sc_lat = sc_q;

    mem_link_reg #(.WORD_W(WORD_W)) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_i      (state_q == ACCESS && dhit && ll_q),
        .set_addr_i (addr_q),
        .clr_i      (state_q == ACCESS && dhit && sc_q),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .chk_addr_i (alu_out_i),
        .link_hit_o (link_hit)
    );
`else
    assign ll_req   = 1'b0;
    assign sc_req   = 1'b0;
    assign sc_lat   = 1'b0;
    assign link_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op) state_d = sc_fail ? DONE : ACCESS;
            ACCESS:  if (dhit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = ((state_q == IDLE) && mem_op) || (state_q == ACCESS);
        dmemREN   = (state_q == ACCESS) && rd_kind_q;
        dmemWEN   = (state_q == ACCESS) && !rd_kind_q;
        dmemaddr  = addr_q;
        dmemstore = store_q;
    end

    always_comb begin
        addr_d      = addr_q;
        store_d     = store_q;
        dest_d      = dest_q;
        regw_d      = regw_q;
        rd_kind_d   = rd_kind_q;
        wb_valid_d  = wb_valid_q;
        wb_regw_d   = wb_regw_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        halt_d      = halt_q;
        stall_cnt_d = stall_cnt_q;
        if (mem_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    addr_d     = alu_out_i;
                    store_d    = rdat2_i;
                    dest_d     = RegDest_i;
                    regw_d     = RegW_i;
                    rd_kind_d  = DRen_i | ll_req;
                    wb_valid_d = 1'b0;
                    // A failed SC skips the cache entirely and reports 0.
                    if (sc_fail) begin
                        wb_valid_d = 1'b1;
                        wb_regw_d  = 1'b1;
                        wb_rd_d    = RegDest_i;
                        wb_data_d  = '0;
                    end
                end else if (halt_q) begin
                    wb_valid_d = 1'b0;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_regw_d  = RegW_i;
                    wb_rd_d    = RegDest_i;
                    wb_data_d  = alu_out_i;
                    halt_d     = halt_i;
                end
            end
            ACCESS: begin
                if (dhit) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = dest_q;
                    wb_regw_d  = rd_kind_q ? regw_q : sc_lat;
                    wb_data_d  = rd_kind_q ? dmemload : (sc_lat ? SC_OK_WORD : addr_q);
                end
            end
            default: wb_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q      <= '0;
            store_q     <= '0;
            dest_q      <= '0;
            regw_q      <= 1'b0;
            rd_kind_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_regw_q   <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            addr_q      <= addr_d;
            store_q     <= store_d;
            dest_q      <= dest_d;
            regw_q      <= regw_d;
            rd_kind_q   <= rd_kind_d;
            wb_valid_q  <= wb_valid_d;
            wb_regw_q   <= wb_regw_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_regw   = wb_regw_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign halt_o    = halt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl (default build): directed and random instructions
// checked against a transaction-level model of write-back, stall and halt.
module tb_mem_access_ctrl;

    localparam int WW = 32;
    localparam int RW = 5;
    localparam int CW = 3;

    logic          CLK, nRST;
    logic          DRen_i, DWen_i, RegW_i, halt_i, dhit;
    logic [RW-1:0] RegDest_i;
    logic [WW-1:0] alu_out_i, rdat2_i, dmemload;
    logic          dmemREN, dmemWEN, mem_stall, wb_valid, wb_regw, halt_o;
    logic [WW-1:0] dmemaddr, dmemstore, wb_data;
    logic [RW-1:0] wb_rd;
    logic [CW-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int model_stalls = 0;

    mem_access_ctrl #(.WORD_W(WW), .REG_W(RW), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .DRen_i(DRen_i), .DWen_i(DWen_i), .RegW_i(RegW_i), .RegDest_i(RegDest_i),
        .alu_out_i(alu_out_i), .rdat2_i(rdat2_i), .halt_i(halt_i),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_regw(wb_regw), .wb_rd(wb_rd),
        .wb_data(wb_data), .halt_o(halt_o), .stall_cnt(stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [CW-1:0] sat_cnt(input int n);
        return (n > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
    endfunction

    task automatic idle_inputs();
        DRen_i = 0; DWen_i = 0; RegW_i = 0; RegDest_i = '0;
        alu_out_i = '0; rdat2_i = '0; halt_i = 0; dhit = 0; dmemload = '0;
    endtask

    // Runs one instruction starting and ending at a falling edge with the DUT in IDLE.
    // kind: 0 = ALU op, 1 = load, 2 = store, 3 = load+store flags together.
    task automatic run_op(input int kind, input logic [RW-1:0] rd, input logic regw,
                          input logic [WW-1:0] a, input logic [WW-1:0] sd,
                          input int lat, input logic [WW-1:0] ld);
        logic          is_mem, is_rd, exp_regw;
        logic [WW-1:0] exp_data;
        is_mem = (kind != 0);
        is_rd  = (kind == 1) || (kind == 3);
        DRen_i = is_rd; DWen_i = (kind == 2) || (kind == 3);
        RegW_i = regw; RegDest_i = rd; alu_out_i = a; rdat2_i = sd; dhit = 0; halt_i = 0;
        #1;
        checks++;
        if (mem_stall !== is_mem) begin
            failures++; $display("FAIL detect_stall kind=%0d got=%b exp=%b", kind, mem_stall, is_mem);
        end
        if (!is_mem) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (wb_valid !== 1'b1 || wb_regw !== regw || wb_rd !== rd || wb_data !== a) begin
                failures++;
                $display("FAIL passthrough got v=%b w=%b rd=%0d d=%h exp v=1 w=%b rd=%0d d=%h",
                         wb_valid, wb_regw, wb_rd, wb_data, regw, rd, a);
            end
            checks++;
            if (stall_cnt !== sat_cnt(model_stalls)) begin
                failures++; $display("FAIL stall_cnt_alu got=%0d exp=%0d", stall_cnt, sat_cnt(model_stalls));
            end
            return;
        end
        @(posedge CLK);
        for (int i = 1; i <= lat; i++) begin
            @(negedge CLK);
            dhit = (i == lat);
            dmemload = (i == lat) ? ld : $urandom;
            #1;
            checks++;
            if (dmemREN !== is_rd || dmemWEN !== !is_rd || mem_stall !== 1'b1 || dmemaddr !== a
                || (!is_rd && dmemstore !== sd)) begin
                failures++;
                $display("FAIL access cyc=%0d got ren=%b wen=%b st=%b ad=%h sd=%h exp ren=%b wen=%b st=1 ad=%h sd=%h",
                         i, dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore, is_rd, !is_rd, a, sd);
            end
            @(posedge CLK);
        end
        model_stalls += lat + 1;
        exp_data = is_rd ? ld : a;
        exp_regw = is_rd ? regw : 1'b0;
        @(negedge CLK);
        dhit = 0;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
            failures++; $display("FAIL done_req got st=%b ren=%b wen=%b exp 0 0 0", mem_stall, dmemREN, dmemWEN);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_regw !== exp_regw || wb_rd !== rd || wb_data !== exp_data) begin
            failures++;
            $display("FAIL mem_wb got v=%b w=%b rd=%0d d=%h exp v=1 w=%b rd=%0d d=%h",
                     wb_valid, wb_regw, wb_rd, wb_data, exp_regw, rd, exp_data);
        end
        checks++;
        if (stall_cnt !== sat_cnt(model_stalls)) begin
            failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, sat_cnt(model_stalls));
        end
        @(posedge CLK); @(negedge CLK);
        checks++;
        if (wb_valid !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
            failures++; $display("FAIL after_done got v=%b ren=%b wen=%b exp 0 0 0", wb_valid, dmemREN, dmemWEN);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        #1;
        checks++;
        if (wb_valid !== 0 || wb_regw !== 0 || wb_rd !== '0 || wb_data !== '0 || halt_o !== 0
            || stall_cnt !== '0 || dmemREN !== 0 || dmemWEN !== 0 || mem_stall !== 0) begin
            failures++;
            $display("FAIL reset_state got v=%b w=%b rd=%0d d=%h h=%b sc=%0d ren=%b wen=%b st=%b exp all 0",
                     wb_valid, wb_regw, wb_rd, wb_data, halt_o, stall_cnt, dmemREN, dmemWEN, mem_stall);
        end
        model_stalls = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
    endtask

    task automatic test_passthrough();
        run_op(0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 32'h0);
        run_op(0, 5'd31, 1'b0, 32'hFFFF_0001, 32'h0, 0, 32'h0);
    endtask

    task automatic test_load();
        run_op(1, 5'd7, 1'b1, 32'h40, 32'h0, 3, 32'hDEAD_BEEF);
        checks++;
        if (stall_cnt !== 3'd4) begin
            failures++; $display("FAIL load_stall_cnt got=%0d exp=4", stall_cnt);
        end
    endtask

    task automatic test_store();
        run_op(2, 5'd9, 1'b1, 32'h80, 32'hCAFE, 1, 32'h0);
    endtask

    task automatic test_both();
        run_op(3, 5'd3, 1'b1, 32'h200, 32'h5555, 2, 32'h0BAD_F00D);
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(0, 3)), RW'($urandom), 1'($urandom), $urandom, $urandom,
                   int'($urandom_range(1, 4)), $urandom);
        end
    endtask

    task automatic test_reset_mid_access();
        DRen_i = 1; DWen_i = 0; alu_out_i = 32'h300; RegDest_i = 5'd4; RegW_i = 1;
        @(posedge CLK); @(negedge CLK);
        #1;
        checks++;
        if (dmemREN !== 1'b1) begin
            failures++; $display("FAIL mid_access_req got=%b exp=1", dmemREN);
        end
        nRST = 0;
        #1;
        checks++;
        if (dmemREN !== 1'b0 || wb_valid !== 1'b0 || stall_cnt !== '0) begin
            failures++; $display("FAIL async_reset got ren=%b v=%b sc=%0d exp 0 0 0", dmemREN, wb_valid, stall_cnt);
        end
        idle_inputs();
        model_stalls = 0;
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
    endtask

    task automatic test_halt();
        halt_i = 1; RegW_i = 0;
        @(posedge CLK); @(negedge CLK);
        halt_i = 0;
        checks++;
        if (halt_o !== 1'b1) begin
            failures++; $display("FAIL halt_set got=%b exp=1", halt_o);
        end
        DRen_i = 1; alu_out_i = 32'h44; RegW_i = 1; RegDest_i = 5'd2;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || dmemREN !== 1'b0) begin
            failures++; $display("FAIL halted_load_detect got st=%b ren=%b exp 0 0", mem_stall, dmemREN);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (halt_o !== 1'b1 || dmemREN !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0
                || stall_cnt !== sat_cnt(model_stalls)) begin
                failures++;
                $display("FAIL halted cyc=%0d got h=%b ren=%b v=%b st=%b sc=%0d exp 1 0 0 0 %0d",
                         i, halt_o, dmemREN, wb_valid, mem_stall, stall_cnt, sat_cnt(model_stalls));
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_both();
        test_back_to_back_random();
        test_reset_mid_access();
        test_passthrough();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
